// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - output stream bundle for ram_stream_reader
interface ram_stream_reader_if #(
  parameter int DATA_W = 16
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams a block of words from an async-read RAM port
module ram_stream_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [ADDR_W-1:0]    i_base,
  input  logic [ADDR_W:0]      i_len,
  input  logic                 i_abort,
  output logic [ADDR_W-1:0]    o_rd_addr,
  input  logic [DATA_W-1:0]    i_rd_data,
  ram_stream_reader_if.master  m_if,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DATA_W-1:0]    o_chk
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W:0]     r_remaining;
  logic                r_m_valid;
  logic                r_m_last;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_done;
  logic [DATA_W-1:0]   r_chk;

  logic w_accept;
  logic w_empty;
  logic w_abort;
  logic w_hs;
  logic w_load;
  logic w_rem_one;

  assign w_accept  = (r_state == S_IDLE) && i_start && (i_len != '0);
  assign w_empty   = (r_state == S_IDLE) && i_start && (i_len == '0);
  assign w_abort   = (r_state != S_IDLE) && i_abort;
  assign w_rem_one = (r_remaining == (ADDR_W+1)'(1));
  // abort masks both the handshake and the load of the same cycle
  assign w_hs      = r_m_valid && m_if.m_ready && !w_abort;
  assign w_load    = (r_state == S_RUN) && (r_remaining != '0) &&
                     (!r_m_valid || m_if.m_ready) && !w_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_abort)                 w_next = S_IDLE;
        else if (w_load && w_rem_one) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_abort)               w_next = S_IDLE;
        else if (w_hs && r_m_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_data    <= '0;
      r_done      <= 1'b0;
      r_chk       <= '0;
    end else begin
      r_done <= w_empty || ((r_state == S_DRAIN) && w_hs && r_m_last);

      if (w_accept) begin
        r_rd_addr   <= i_base;
        r_remaining <= i_len;
      end else if (w_load) begin
        r_rd_addr   <= r_rd_addr + 1'b1;
        r_remaining <= r_remaining - (ADDR_W+1)'(1);
      end

      if (w_load) begin
        r_m_data <= i_rd_data;
      end

      if (w_abort) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end else if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_last  <= w_rem_one;
      end else if (w_hs) begin
        r_m_valid <= 1'b0;
      end

      if (w_accept || w_empty) begin
        r_chk <= '0;
      end else if (w_hs) begin
        r_chk <= r_chk ^ r_m_data;
      end
    end
  end

  assign o_rd_addr    = r_rd_addr;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_chk        = r_chk;
  assign m_if.m_valid = r_m_valid;
  assign m_if.m_data  = r_m_data;
  assign m_if.m_last  = r_m_last;

endmodule
